mux4to1_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit 4:1 result path (an internal `mux4to1` instance) among four requesters. Requester i presents data on `R<i>` and raises `Req[i]`. The arbiter drives the mux `Selector` and issues a one-hot `Grant`. It holds the grant for a bounded burst of accepted transfers, then rotates priority. It sits between four producer units and a single downstream consumer that applies backpressure through `Ready`.

---
 rtl/mux4to1_arbiter.sv | 126 ++++++++++++
 tb/tb_mux4to1_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mux4to1_arbiter.sv
// Round-robin arbiter sharing a 4:1 result mux, bounded bursts per grant.
// Grant one cycle after request, seamless handover; Ready low stalls the owner without revoking it.

module mux4to1 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = r0;
      2'd1:    y = r1;
      2'd2:    y = r2;
      default: y = r3;
    endcase
  end
endmodule

module mux4to1_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] R0,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] R3,
  input  logic             Ready,
  output logic [3:0]       Grant,
  output logic [1:0]       Selector,
  output logic [WIDTH-1:0] Result,
  output logic             Valid,
  output logic             Busy
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [3:0] grant_n;
  logic [1:0] sel_n, last, last_n;
  logic [3:0] count, count_n;
  logic       xfer, release_c;
  logic [1:0] winner;

  // First requester at or after last+1, wrapping, with last itself checked last.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] from);
    logic [1:0] idx;
    pick = from;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (req[idx]) pick = idx;
    end
  endfunction

  mux4to1 #(.WIDTH(WIDTH)) u_mux (
    .sel (Selector),
    .r0  (R0),
    .r1  (R1),
    .r2  (R2),
    .r3  (R3),
    .y   (Result)
  );

  assign Busy      = (state == GRANT);
  assign Valid     = Busy && Req[Selector];
  assign xfer      = Valid && Ready;
  assign release_c = !Req[Selector] || (xfer && (count == 4'(MAX_BURST - 1)));
  // On release the priority pointer moves to the outgoing owner before re-arbitrating.
  assign winner    = pick(Req, (state == GRANT) ? Selector : last);

  always_comb begin
    state_n = state;
    grant_n = Grant;
    sel_n   = Selector;
    last_n  = last;
    count_n = count;
    case (state)
      IDLE: begin
        grant_n = 4'b0000;
        if (|Req) begin
          state_n = GRANT;
          grant_n = 4'b0001 << winner;
          sel_n   = winner;
          count_n = 4'd0;
        end
      end
      default: begin
        if (release_c) begin
          last_n  = Selector;
          count_n = 4'd0;
          if (|Req) begin
            grant_n = 4'b0001 << winner;
            sel_n   = winner;
          end else begin
            state_n = IDLE;
            grant_n = 4'b0000;
          end
        end else if (xfer) begin
          count_n = count + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      Grant    <= 4'b0000;
      Selector <= 2'b00;
      last     <= 2'd3;
      count    <= 4'd0;
    end else begin
      state    <= state_n;
      Grant    <= grant_n;
      Selector <= sel_n;
      last     <= last_n;
      count    <= count_n;
    end
  end
endmodule

// File: tb/tb_mux4to1_arbiter.sv
// Directed bench for mux4to1_arbiter; accepted transfers are scored against a queue of expected beats.

module tb_mux4to1_arbiter;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'hCAFEBABE;
  localparam logic [31:0] D2 = 32'h0BADF00D;
  localparam logic [31:0] D3 = 32'h01234567;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  grant;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  Req = 4'b1111;
  logic        Ready = 1'b0;
  logic [31:0] R0 = D0, R1 = D1, R2 = D2, R3 = D3;
  logic [3:0]  Grant;
  logic [1:0]  Selector;
  logic [31:0] Result;
  logic        Valid, Busy;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  mux4to1_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .Req(Req), .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .Ready(Ready), .Grant(Grant), .Selector(Selector), .Result(Result),
    .Valid(Valid), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic [3:0] g, input int n);
    beat_t b;
    b.result = res;
    b.grant  = g;
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1; Req = 4'b0000; Ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted transfer must match the next expected beat.
  always @(negedge clk) begin
    if (Valid && Ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got result %h grant %b, expected none", Result, Grant);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("xfer_result", Result, e.result);
        check("xfer_grant", {28'd0, Grant}, {28'd0, e.grant});
      end
    end
  end

  initial begin
    // Reset held with all requests present
    tick(); tick(); tick();
    check("rst_grant", {28'd0, Grant}, 32'd0);
    check("rst_sel", {30'd0, Selector}, 32'd0);
    check("rst_valid", {31'd0, Valid}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_result", Result, D0);
    rst = 1'b0;
    tick();
    check("post_rst_grant", {28'd0, Grant}, 32'h1);

    // Single requester across burst boundaries
    do_reset();
    Req = 4'b0001; Ready = 1'b1;
    push(D0, 4'b0001, 10);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("single_valid", {31'd0, Valid}, 32'd1);
      check("single_grant", {28'd0, Grant}, 32'h1);
      tick();
    end
    Req = 4'b0000; Ready = 1'b0;
    tick();
    check("single_drain", exp_q.size(), 32'd0);

    // Full rotation
    do_reset();
    Req = 4'b1111; Ready = 1'b1;
    push(D0, 4'b0001, 4); push(D1, 4'b0010, 4); push(D2, 4'b0100, 4);
    push(D3, 4'b1000, 4); push(D0, 4'b0001, 4);
    tick();
    for (int i = 0; i < 20; i++) begin
      check("rot_sel", {30'd0, Selector}, (i / 4) % 4);
      tick();
    end
    Req = 4'b0000; Ready = 1'b0;
    tick();
    check("rot_drain", exp_q.size(), 32'd0);

    // Backpressure then exactly four beats before handing to requester 1
    do_reset();
    Req = 4'b0100; Ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_grant", {28'd0, Grant}, 32'h4);
      check("bp_valid", {31'd0, Valid}, 32'd1);
      check("bp_result", Result, D2);
      tick();
    end
    Req = 4'b0110; Ready = 1'b1;
    push(D2, 4'b0100, 4); push(D1, 4'b0010, 2);
    for (int i = 0; i < 6; i++) begin
      check("bp_rel_grant", {28'd0, Grant}, (i < 4) ? 32'h4 : 32'h2);
      tick();
    end
    Req = 4'b0000; Ready = 1'b0;
    tick();
    check("bp_drain", exp_q.size(), 32'd0);

    // Owner drops request after two beats
    do_reset();
    Req = 4'b0011; Ready = 1'b1;
    push(D0, 4'b0001, 2); push(D1, 4'b0010, 2);
    tick(); tick(); tick();
    Req = 4'b0010;
    #1;
    check("drop_valid", {31'd0, Valid}, 32'd0);
    tick();
    check("drop_grant", {28'd0, Grant}, 32'h2);
    check("drop_result", Result, D1);
    tick(); tick();
    Req = 4'b0000; Ready = 1'b0;
    tick();
    check("drop_drain", exp_q.size(), 32'd0);

    // Reset in the middle of a burst
    do_reset();
    Req = 4'b0110; Ready = 1'b1;
    push(D1, 4'b0010, 2);
    tick();
    check("mid_owner", {28'd0, Grant}, 32'h2);
    tick(); tick();
    rst = 1'b1; Ready = 1'b0;
    tick();
    check("mid_rst_grant", {28'd0, Grant}, 32'd0);
    check("mid_rst_sel", {30'd0, Selector}, 32'd0);
    check("mid_rst_busy", {31'd0, Busy}, 32'd0);
    check("mid_rst_valid", {31'd0, Valid}, 32'd0);
    rst = 1'b0; Req = 4'b1111;
    tick();
    check("mid_first_grant", {28'd0, Grant}, 32'h1);
    tick();
    check("mid_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
